// File: rtl/aes_key_sched_iter.sv
// Iterative AES key-schedule engine (AES-128/192/256).
// Emits one 32-bit round-key word per accepted handshake. It keeps a window of
// the last Nk words and uses a single 4-byte SubWord lookup.
//
// Handshake: word_out/word_idx are meaningful only while word_valid is high.
// A word is consumed on a rising clk edge where word_valid && word_ready.
// While no word is consumed, word_valid, word_out and word_idx hold their values.
module aes_key_sched_iter #(
  parameter logic [2:0] MODES_EN = 3'b111,
  parameter int         IDX_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [255:0]     key_in,
  output logic             busy,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [31:0]      word_out,
  output logic [IDX_W-1:0] word_idx,
  output logic             done,
  output logic             err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // FIPS-197 S-box, byte 0x00 in the most significant position
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    sbox = SBOX_TBL[(11'd2047 - {a, 3'b000}) -: 8];
  endfunction

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      word_out_q, word_out_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [2:0]       phase_q, phase_d;   // word_idx mod Nk
  logic [2:0]       nkm1_q, nkm1_d;     // Nk-1
  logic [IDX_W-1:0] nwm1_q, nwm1_d;     // Nw-1
  logic [31:0]      win_q [8];
  logic [31:0]      win_d [8];

  logic             mode_ok;
  logic [2:0]       mode_nkm1;
  logic [IDX_W-1:0] mode_nwm1;
  logic [IDX_W-1:0] idx_nx;
  logic [2:0]       phase_nx;
  logic             in_key;
  logic [31:0]      sub_in, sub_out, temp, new_word;

  // Decode the requested mode into legality and schedule lengths
  always_comb begin
    mode_ok   = 1'b0;
    mode_nkm1 = 3'd3;
    mode_nwm1 = IDX_W'(43);
    case (mode)
      2'd0: begin mode_ok = MODES_EN[0]; mode_nkm1 = 3'd3; mode_nwm1 = IDX_W'(43); end
      2'd1: begin mode_ok = MODES_EN[1]; mode_nkm1 = 3'd5; mode_nwm1 = IDX_W'(51); end
      2'd2: begin mode_ok = MODES_EN[2]; mode_nkm1 = 3'd7; mode_nwm1 = IDX_W'(59); end
      default: mode_ok = 1'b0;
    endcase
  end

  // Next-word datapath: temp selection with the single SubWord lookup
  always_comb begin
    idx_nx   = word_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    phase_nx = (phase_q == nkm1_q) ? 3'd0 : phase_q + 3'd1;
    in_key   = (idx_nx <= {{(IDX_W-3){1'b0}}, nkm1_q});
    sub_in   = (phase_nx == 3'd0) ? {word_out_q[23:0], word_out_q[31:24]} : word_out_q;
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (phase_nx == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nkm1_q == 3'd7 && phase_nx == 3'd4)
      temp = sub_out;
    else
      temp = word_out_q;
    // win_q[0] holds w[i-Nk+1], which is w[(i+1)-Nk]
    new_word = win_q[0] ^ temp;
  end

  // Control: IDLE/RUN sequencing, handshake advance, window shift, Rcon step
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    word_out_d = word_out_q;
    word_idx_d = word_idx_q;
    rcon_d     = rcon_q;
    phase_d    = phase_q;
    nkm1_d     = nkm1_q;
    nwm1_d     = nwm1_q;
    for (int k = 0; k < 8; k++) win_d[k] = win_q[k];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode_ok) begin
            state_d = S_RUN;
            for (int k = 0; k < 8; k++) win_d[k] = key_in[255 - 32*k -: 32];
            nkm1_d     = mode_nkm1;
            nwm1_d     = mode_nwm1;
            word_out_d = key_in[255:224];
            word_idx_d = '0;
            phase_d    = 3'd0;
            valid_d    = 1'b1;
            busy_d     = 1'b1;
            rcon_d     = 8'h01;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (valid_q && word_ready) begin
          if (word_idx_q == nwm1_q) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            word_idx_d = idx_nx;
            phase_d    = phase_nx;
            if (in_key) begin
              // Key words are still sitting in the window, unshifted
              word_out_d = win_q[idx_nx[2:0]];
            end else begin
              word_out_d = new_word;
              for (int k = 0; k < 7; k++) win_d[k] = win_q[k+1];
              win_d[nkm1_q] = new_word;
              if (phase_nx == 3'd0)
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      word_out_q <= '0;
      word_idx_q <= '0;
      rcon_q     <= 8'h01;
      phase_q    <= 3'd0;
      nkm1_q     <= 3'd3;
      nwm1_q     <= IDX_W'(43);
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      word_out_q <= word_out_d;
      word_idx_q <= word_idx_d;
      rcon_q     <= rcon_d;
      phase_q    <= phase_d;
      nkm1_q     <= nkm1_d;
      nwm1_q     <= nwm1_d;
      for (int k = 0; k < 8; k++) win_q[k] <= win_d[k];
    end
  end

  assign busy       = busy_q;
  assign word_valid = valid_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_out   = word_out_q;
  assign word_idx   = word_idx_q;

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Bench for aes_key_sched_iter: FIPS-197 vectors, random keys, random
// backpressure, mid-run start pulses, illegal/disabled modes and mid-run reset.
module tb_aes_key_sched_iter;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, word_ready;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy, word_valid, done, err;
  logic [31:0]  word_out;
  logic [5:0]   word_idx;

  logic         start_b, ready_b;
  logic [1:0]   mode_b;
  logic         busy_b, valid_b, done_b, err_b;
  logic [31:0]  word_out_b;
  logic [5:0]   word_idx_b;

  aes_key_sched_iter #(.MODES_EN(3'b111), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy), .word_valid(word_valid), .word_ready(word_ready),
    .word_out(word_out), .word_idx(word_idx), .done(done), .err(err)
  );

  aes_key_sched_iter #(.MODES_EN(3'b011), .IDX_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .key_in(key_in),
    .busy(busy_b), .word_valid(valid_b), .word_ready(ready_b),
    .word_out(word_out_b), .word_idx(word_idx_b), .done(done_b), .err(err_b)
  );

  // ---------------- reference model ----------------
  logic [7:0]  sbox_m [256];
  logic [31:0] ref_w  [60];
  logic [31:0] got_w  [60];
  logic [31:0] exp_q [$];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] rc;
    rc = 8'h01;
    for (int n = 1; n < j; n++) rc = xtime(rc);
    return rc;
  endfunction

  task automatic build_ref(input logic [255:0] key, input int nk);
    logic [31:0] t;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        ref_w[i] = key[255 - 32*i -: 32];
      end else begin
        t = ref_w[i-1];
        if (i % nk == 0)
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
        else if (nk == 8 && i % 8 == 4)
          t = sub_word(t);
        ref_w[i] = ref_w[i-nk] ^ t;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One full run; abort_at >= 0 returns while word abort_at is presented
  task automatic run(input logic [1:0] m, input logic [255:0] key, input bit rnd_ready,
                     input bit mid_start, input int abort_at);
    int nk, nw, idx, cyc;
    bit hs;
    nk = (m == 2'd0) ? 4 : (m == 2'd1) ? 6 : 8;
    nw = 4 * (nk + 7);
    build_ref(key, nk);
    exp_q.delete();
    for (int i = 0; i < nw; i++) exp_q.push_back(ref_w[i]);
    start = 1'b1; mode = m; key_in = key; word_ready = 1'b0;
    step();
    start = 1'b0;
    key_in = rand_key();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_valid", 64'(word_valid), 64'd1);
    chk("start_done_low", 64'(done), 64'd0);
    idx = 0; cyc = 0;
    while (exp_q.size() > 0) begin
      if (cyc > 600) begin
        chk("run_timeout", 64'(cyc), 64'd0);
        break;
      end
      chk("word_out", 64'(word_out), 64'(exp_q[0]));
      chk("word_idx", 64'(word_idx), 64'(idx));
      chk("run_valid", 64'(word_valid), 64'd1);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_no_done", 64'(done), 64'd0);
      if (idx == abort_at) return;
      word_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_start && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        mode = 2'($urandom_range(0, 3));
      end
      hs = word_ready;
      if (hs) got_w[idx] = word_out;
      step();
      start = 1'b0;
      cyc++;
      if (hs) begin
        void'(exp_q.pop_front());
        idx++;
      end
    end
    chk("end_done", 64'(done), 64'd1);
    chk("end_valid", 64'(word_valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_err", 64'(err), 64'd0);
    word_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; key_in = '0; word_ready = 1'b0;
    start_b = 1'b0; mode_b = 2'd0; ready_b = 1'b0;
    build_sbox();
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_word_out", 64'(word_out), 64'd0);
    chk("rst_word_idx", 64'(word_idx), 64'd0);
    rst_n = 1'b1;
    step();

    // FIPS-197 vectors, back-to-back runs at full throughput
    run(2'd0, K128, 1'b0, 1'b0, -1);
    chk("aes128_w4", 64'(got_w[4]), 64'h a0fafe17);
    chk("aes128_w43", 64'(got_w[43]), 64'h b6630ca6);
    run(2'd1, K192, 1'b0, 1'b0, -1);
    chk("aes192_w6", 64'(got_w[6]), 64'h fe0c91f7);
    chk("aes192_w51", 64'(got_w[51]), 64'h 01002202);
    run(2'd2, K256, 1'b0, 1'b0, -1);
    chk("aes256_w8", 64'(got_w[8]), 64'h 9ba35411);
    chk("aes256_w59", 64'(got_w[59]), 64'h 706c631e);

    // Backpressure and ignored start pulses mid-run
    run(2'd0, K128, 1'b1, 1'b1, -1);
    chk("stall128_w4", 64'(got_w[4]), 64'h a0fafe17);
    chk("stall128_w43", 64'(got_w[43]), 64'h b6630ca6);

    // Random keys in all modes
    for (int r = 0; r < 4; r++)
      run(2'($urandom_range(0, 2)), rand_key(), 1'b1, 1'b1, -1);

    // Illegal mode on the fully enabled instance
    step();
    start = 1'b1; mode = 2'd3;
    step();
    start = 1'b0;
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_busy", 64'(busy), 64'd0);
    chk("ill_valid", 64'(word_valid), 64'd0);
    chk("ill_done", 64'(done), 64'd0);
    step();
    chk("ill_err_pulse", 64'(err), 64'd0);
    chk("ill_valid_after", 64'(word_valid), 64'd0);

    // Disabled AES-256 on the 128/192-only instance, then a legal request
    start_b = 1'b1; mode_b = 2'd2;
    step();
    start_b = 1'b0;
    chk("dis_err", 64'(err_b), 64'd1);
    chk("dis_busy", 64'(busy_b), 64'd0);
    chk("dis_valid", 64'(valid_b), 64'd0);
    step();
    chk("dis_err_pulse", 64'(err_b), 64'd0);
    chk("dis_valid_after", 64'(valid_b), 64'd0);
    start_b = 1'b1; mode_b = 2'd0; key_in = K128;
    step();
    start_b = 1'b0;
    chk("en_valid", 64'(valid_b), 64'd1);
    chk("en_err", 64'(err_b), 64'd0);
    chk("en_w0", 64'(word_out_b), 64'h 2b7e1516);

    // Reset in the middle of an AES-256 run
    run(2'd2, rand_key(), 1'b0, 1'b0, 20);
    rst_n = 1'b0;
    step();
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_valid", 64'(word_valid), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_word_out", 64'(word_out), 64'd0);
    chk("mrst_word_idx", 64'(word_idx), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mrst_no_done", 64'(done), 64'd0);
    chk("mrst_idle_valid", 64'(word_valid), 64'd0);
    run(2'd0, K128, 1'b0, 1'b0, -1);
    chk("post_rst_w4", 64'(got_w[4]), 64'h a0fafe17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
